// File: rtl/citometer_pkg.sv
// rtl/citometer_pkg.sv - shared types and widths for the pulse event detector
package citometer_pkg;

    localparam int DATA_W     = 14;
    localparam int BASE_FRAC  = 10;
    localparam int PEAK_W     = 15;
    localparam int WIDTH_W    = 16;
    localparam int AREA_W     = 32;
    localparam int TIME_W     = 32;
    localparam int FLAG_W     = 2;
    localparam int DROP_W     = 16;
    localparam int FLAG_TRUNC = 0;
    localparam int FLAG_DROP  = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    typedef struct packed {
        logic [PEAK_W-1:0]  peak;
        logic [WIDTH_W-1:0] width;
        logic [AREA_W-1:0]  area;
        logic [TIME_W-1:0]  tstamp;
        logic [FLAG_W-1:0]  flags;
    } event_t;

endpackage

// File: rtl/baseline_tracker.sv
// rtl/baseline_tracker.sv - first-sample load plus shift IIR baseline with freeze
module baseline_tracker
    import citometer_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic              freeze,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] base_int
);

    localparam int BW = DATA_W + BASE_FRAC;

    logic [BW-1:0]      base;
    logic               loaded;
    logic signed [BW:0] diff;
    logic [BW-1:0]      step;

    assign diff = $signed({1'b0, sample, {BASE_FRAC{1'b0}}}) - $signed({1'b0, base});
    assign step = BW'(diff >>> SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            base   <= '0;
            loaded <= 1'b0;
        end else if (sample_valid) begin
            if (!loaded) begin
                base   <= {sample, {BASE_FRAC{1'b0}}};
                loaded <= 1'b1;
            end else if (!freeze) begin
                base <= base + step;
            end
        end
    end

    // Until the first load the sample itself is the baseline, so d = 0 and nothing triggers.
    assign base_int = loaded ? base[BW-1:BASE_FRAC] : sample;

endmodule

// File: rtl/pulse_event_detector.sv
// rtl/pulse_event_detector.sv - baseline-subtracted hysteresis pulse detector with event record output
module pulse_event_detector
    import citometer_pkg::*;
#(
    parameter int BASE_SHIFT = 8,
    parameter int HOLDOFF    = 16,
    parameter int MAX_WIDTH  = 4096
) (
    input  logic               CLOCK_IN,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic [DATA_W-1:0]  SAMPLE_IN,
    input  logic               SAMPLE_VALID,
    input  logic [DATA_W-1:0]  THRESH_HI,
    input  logic [DATA_W-1:0]  THRESH_LO,
    output logic               EVENT_VALID,
    input  logic               EVENT_READY,
    output logic [PEAK_W-1:0]  EVENT_PEAK,
    output logic [WIDTH_W-1:0] EVENT_WIDTH,
    output logic [AREA_W-1:0]  EVENT_AREA,
    output logic [TIME_W-1:0]  EVENT_TIME,
    output logic [FLAG_W-1:0]  EVENT_FLAGS,
    output logic [DROP_W-1:0]  DROP_COUNT
);

    state_t              state, state_n;
    logic [PEAK_W-1:0]   peak, peak_n;
    logic [WIDTH_W-1:0]  width, width_n;
    logic [AREA_W-1:0]   area, area_n;
    logic [TIME_W-1:0]   tstamp, tstamp_n;
    logic [15:0]         hold_cnt, hold_n;
    logic [TIME_W-1:0]   sample_cnt;
    logic                emit, trunc, start;
    logic [DATA_W-1:0]   base_int;
    logic signed [DATA_W:0] d;
    logic [DATA_W-1:0]   dpos;
    logic                above_hi, below_lo;
    event_t              ev, new_ev;
    logic                ev_valid, drop_pend;
    logic [DROP_W-1:0]   drop_cnt;

    baseline_tracker #(.SHIFT(BASE_SHIFT)) u_base (
        .clk          (CLOCK_IN),
        .rst          (RESET),
        .sample_valid (SAMPLE_VALID),
        .freeze       ((state != ST_IDLE) || start),
        .sample       (SAMPLE_IN),
        .base_int     (base_int)
    );

    assign d        = $signed({1'b0, SAMPLE_IN}) - $signed({1'b0, base_int});
    assign dpos     = d[DATA_W] ? '0 : d[DATA_W-1:0];
    assign above_hi = d >= $signed({1'b0, THRESH_HI});
    assign below_lo = d <  $signed({1'b0, THRESH_LO});

    always_comb begin
        state_n  = state;
        peak_n   = peak;
        width_n  = width;
        area_n   = area;
        tstamp_n = tstamp;
        hold_n   = hold_cnt;
        emit     = 1'b0;
        trunc    = 1'b0;
        start    = 1'b0;
        if (SAMPLE_VALID) begin
            if (!ENABLE) begin
                state_n = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (above_hi) begin
                            start    = 1'b1;
                            state_n  = ST_PULSE;
                            peak_n   = {1'b0, dpos};
                            width_n  = 16'd1;
                            area_n   = AREA_W'(dpos);
                            tstamp_n = sample_cnt;
                        end
                    end
                    ST_PULSE: begin
                        if (below_lo) begin
                            emit    = 1'b1;
                            state_n = ST_HOLDOFF;
                            hold_n  = '0;
                        end else begin
                            width_n = width + 16'd1;
                            area_n  = area + AREA_W'(dpos);
                            if ({1'b0, dpos} > peak)
                                peak_n = {1'b0, dpos};
                            if (width_n == WIDTH_W'(MAX_WIDTH)) begin
                                emit    = 1'b1;
                                trunc   = 1'b1;
                                state_n = ST_HOLDOFF;
                                hold_n  = '0;
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        if (hold_cnt == 16'(HOLDOFF - 1))
                            state_n = ST_IDLE;
                        else
                            hold_n = hold_cnt + 16'd1;
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_IN) begin
        if (RESET) begin
            state      <= ST_IDLE;
            peak       <= '0;
            width      <= '0;
            area       <= '0;
            tstamp     <= '0;
            hold_cnt   <= '0;
            sample_cnt <= '0;
        end else begin
            state    <= state_n;
            peak     <= peak_n;
            width    <= width_n;
            area     <= area_n;
            tstamp   <= tstamp_n;
            hold_cnt <= hold_n;
            if (SAMPLE_VALID)
                sample_cnt <= sample_cnt + 32'd1;
        end
    end

    always_comb begin
        new_ev                   = '0;
        new_ev.peak              = peak_n;
        new_ev.width             = width_n;
        new_ev.area              = area_n;
        new_ev.tstamp            = tstamp_n;
        new_ev.flags[FLAG_TRUNC] = trunc;
        new_ev.flags[FLAG_DROP]  = drop_pend;
    end

    // A new event replaces the record only if the slot is empty or being accepted this cycle.
    always_ff @(posedge CLOCK_IN) begin
        if (RESET) begin
            ev        <= '0;
            ev_valid  <= 1'b0;
            drop_cnt  <= '0;
            drop_pend <= 1'b0;
        end else if (emit) begin
            if (!ev_valid || EVENT_READY) begin
                ev        <= new_ev;
                ev_valid  <= 1'b1;
                drop_pend <= 1'b0;
            end else begin
                drop_pend <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (ev_valid && EVENT_READY) begin
            ev_valid <= 1'b0;
        end
    end

    assign EVENT_VALID = ev_valid;
    assign EVENT_PEAK  = ev.peak;
    assign EVENT_WIDTH = ev.width;
    assign EVENT_AREA  = ev.area;
    assign EVENT_TIME  = ev.tstamp;
    assign EVENT_FLAGS = ev.flags;
    assign DROP_COUNT  = drop_cnt;

endmodule
